csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file.sv | 165 ++++++++++++++++
 tb/tb_csr_file.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Control/status register file: mode, exception, save, interrupt and timer CSRs.
// Reads are combinational from current state; writes, flushes and timer updates land on the next edge.
module csr_file #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rdata,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wdata,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [5:0]  ecode,
  input  logic [2:0]  esubcode,
  input  logic [31:0] epc,
  output logic [31:0] era,
  output logic [31:0] eentry,
  input  logic [7:0]  hard_int_in,
  input  logic        ipi_int_in,
  output logic        has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  localparam logic [31:0] CRMD_BITS   = 32'h0000_001F;
  localparam logic [31:0] PRMD_BITS   = 32'h0000_0007;
  localparam logic [31:0] ECFG_BITS   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_BITS  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_BITS = 32'hFFFF_FFC0;
  localparam logic [31:0] ALL_BITS    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRMD_RESET  = 32'h0000_0008;

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
  logic [31:0] estat_q, estat_d, era_q, era_d, eentry_q, eentry_d;
  logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];

  logic we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_eentry;
  logic we_save, we_tid, we_tcfg, we_ticlr;
  logic timer_fire;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [31:0] wmask, input logic [31:0] wbits);
    return (old & ~(wmask & wbits)) | (wdata & wmask & wbits);
  endfunction

  assign we_crmd   = csr_we && (csr_num == CSR_CRMD);
  assign we_prmd   = csr_we && (csr_num == CSR_PRMD);
  assign we_ecfg   = csr_we && (csr_num == CSR_ECFG);
  assign we_estat  = csr_we && (csr_num == CSR_ESTAT);
  assign we_era    = csr_we && (csr_num == CSR_ERA);
  assign we_eentry = csr_we && (csr_num == CSR_EENTRY);
  assign we_save   = csr_we && (csr_num[13:2] == CSR_SAVE0[13:2]);
  assign we_tid    = csr_we && (csr_num == CSR_TID);
  assign we_tcfg   = csr_we && (csr_num == CSR_TCFG);
  assign we_ticlr  = csr_we && (csr_num == CSR_TICLR);

  // A TCFG write reloads TVAL, so the countdown pauses for that cycle.
  assign timer_fire = !we_tcfg && tcfg_q[0] && (tval_q == 32'd1);

  always_comb begin
    crmd_d   = we_crmd   ? merge(crmd_q,   csr_wdata, csr_wmask, CRMD_BITS)   : crmd_q;
    prmd_d   = we_prmd   ? merge(prmd_q,   csr_wdata, csr_wmask, PRMD_BITS)   : prmd_q;
    ecfg_d   = we_ecfg   ? merge(ecfg_q,   csr_wdata, csr_wmask, ECFG_BITS)   : ecfg_q;
    estat_d  = we_estat  ? merge(estat_q,  csr_wdata, csr_wmask, ESTAT_BITS)  : estat_q;
    era_d    = we_era    ? merge(era_q,    csr_wdata, csr_wmask, ALL_BITS)    : era_q;
    eentry_d = we_eentry ? merge(eentry_q, csr_wdata, csr_wmask, EENTRY_BITS) : eentry_q;
    tid_d    = we_tid    ? merge(tid_q,    csr_wdata, csr_wmask, ALL_BITS)    : tid_q;
    tcfg_d   = we_tcfg   ? merge(tcfg_q,   csr_wdata, csr_wmask, ALL_BITS)    : tcfg_q;
    for (int i = 0; i < 4; i++) begin
      save_d[i] = (we_save && (csr_num[1:0] == i[1:0]))
                ? merge(save_q[i], csr_wdata, csr_wmask, ALL_BITS) : save_q[i];
    end

    // Hardware commit overrides software writes to the same fields.
    if (excp_flush) begin
      prmd_d[2:0]     = crmd_q[2:0];
      crmd_d[2:0]     = 3'b000;
      era_d           = epc;
      estat_d[21:16]  = ecode;
      estat_d[30:22]  = {6'b0, esubcode};
    end else if (ertn_flush) begin
      crmd_d[2:0]     = prmd_q[2:0];
    end

    estat_d[9:2] = hard_int_in;
    estat_d[12]  = ipi_int_in;
    if (we_ticlr && csr_wdata[0] && csr_wmask[0]) begin
      estat_d[11] = 1'b0;
    end
    if (timer_fire) begin
      estat_d[11] = 1'b1;
    end

    tval_d = tval_q;
    if (we_tcfg) begin
      tval_d = {tcfg_d[31:2], 2'b00};
    end else if (timer_fire) begin
      tval_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'd0;
    end else if (tcfg_q[0] && (tval_q != 32'd0)) begin
      tval_d = tval_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q   <= CRMD_RESET;
      prmd_q   <= 32'd0;
      ecfg_q   <= 32'd0;
      estat_q  <= 32'd0;
      era_q    <= 32'd0;
      eentry_q <= 32'd0;
      tid_q    <= TID_RESET;
      tcfg_q   <= 32'd0;
      tval_q   <= 32'd0;
      for (int i = 0; i < 4; i++) save_q[i] <= 32'd0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_num)
      CSR_CRMD:   csr_rdata = crmd_q;
      CSR_PRMD:   csr_rdata = prmd_q;
      CSR_ECFG:   csr_rdata = ecfg_q;
      CSR_ESTAT:  csr_rdata = estat_q;
      CSR_ERA:    csr_rdata = era_q;
      CSR_EENTRY: csr_rdata = eentry_q;
      14'h30, 14'h31, 14'h32, 14'h33: csr_rdata = save_q[csr_num[1:0]];
      CSR_TID:    csr_rdata = tid_q;
      CSR_TCFG:   csr_rdata = tcfg_q;
      CSR_TVAL:   csr_rdata = tval_q;
      default:    csr_rdata = 32'd0;
    endcase
  end

  assign era     = era_q;
  assign eentry  = eentry_q;
  assign has_int = crmd_q[2] && (|(estat_q[12:0] & ecfg_q[12:0]));

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: masked writes, exception/return commit, timer and interrupt behaviour.
module tb_csr_file;
  localparam logic [31:0] TIDR = 32'hA5A5_0001;
  localparam logic [13:0] A_CRMD = 14'h00, A_PRMD = 14'h01, A_ECFG = 14'h04, A_ESTAT = 14'h05;
  localparam logic [13:0] A_ERA = 14'h06, A_EENTRY = 14'h0C, A_SAVE0 = 14'h30, A_SAVE2 = 14'h32;
  localparam logic [13:0] A_TID = 14'h40, A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_num;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wdata;
  logic        excp_flush, ertn_flush;
  logic [5:0]  ecode;
  logic [2:0]  esubcode;
  logic [31:0] epc, era, eentry;
  logic [7:0]  hard_int_in;
  logic        ipi_int_in, has_int;

  int n_cmp = 0;
  int n_err = 0;

  csr_file #(.TID_RESET(TIDR)) dut (
    .clk(clk), .reset(reset), .csr_num(csr_num), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode),
    .esubcode(esubcode), .epc(epc), .era(era), .eentry(eentry),
    .hard_int_in(hard_int_in), .ipi_int_in(ipi_int_in), .has_int(has_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] data, input logic [31:0] mask);
    csr_num = num; csr_wdata = data; csr_wmask = mask; csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_num = num;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; csr_num = A_CRMD; csr_we = 1'b1; csr_wdata = 32'h0; csr_wmask = 32'hFFFF_FFFF;
    excp_flush = 1'b0; ertn_flush = 1'b0; ecode = '0; esubcode = '0; epc = '0;
    hard_int_in = '0; ipi_int_in = 1'b0;
    tick(); tick();
    reset = 1'b0; csr_we = 1'b0;

    // Reset state, with a concurrent CRMD write overridden by reset.
    read_chk("rst_crmd", A_CRMD, 32'h8);
    read_chk("rst_prmd", A_PRMD, 32'h0);
    read_chk("rst_estat", A_ESTAT, 32'h0);
    read_chk("rst_tid", A_TID, TIDR);
    read_chk("rst_tval", A_TVAL, 32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    check("rst_era", era, 32'h0);

    // Masked write with read-before-write visibility.
    csr_num = A_CRMD; csr_wdata = 32'h7; csr_wmask = 32'h3; csr_we = 1'b1;
    #1;
    check("crmd_rbw", csr_rdata, 32'h8);
    tick();
    csr_we = 1'b0;
    read_chk("crmd_mask3", A_CRMD, 32'hB);

    csr_write(14'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_chk("unimpl_rd0", 14'h02, 32'h0);
    csr_write(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_chk("ecfg_bits", A_ECFG, 32'h1BFF);
    csr_write(A_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("eentry_out", eentry, 32'hFFFF_FFC0);
    csr_write(A_PRMD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_chk("prmd_bits", A_PRMD, 32'h7);
    csr_write(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_chk("estat_bits", A_ESTAT, 32'h3);
    check("int_ie_off", {31'b0, has_int}, 32'h0);
    csr_write(A_ESTAT, 32'h0, 32'h3);
    csr_write(A_SAVE2, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    read_chk("save2", A_SAVE2, 32'hDEAD_BEEF);
    read_chk("save0", A_SAVE0, 32'h0);
    csr_write(A_TID, 32'h1234_5678, 32'h0000_FFFF);
    read_chk("tid_mask", A_TID, 32'hA5A5_5678);
    read_chk("ticlr_rd0", A_TICLR, 32'h0);

    // Sampled interrupt lines.
    hard_int_in = 8'h81; ipi_int_in = 1'b1;
    tick();
    read_chk("estat_irq", A_ESTAT, 32'h1204);
    hard_int_in = 8'h00; ipi_int_in = 1'b0;
    tick();
    read_chk("estat_irq0", A_ESTAT, 32'h0);

    // Exception entry and return.
    csr_write(A_PRMD, 32'h0, 32'hFFFF_FFFF);
    csr_write(A_CRMD, 32'h7, 32'h7);
    read_chk("crmd_f", A_CRMD, 32'hF);
    excp_flush = 1'b1; ecode = 6'h0B; esubcode = 3'h5; epc = 32'h1C00_0100;
    tick();
    excp_flush = 1'b0;
    read_chk("excp_prmd", A_PRMD, 32'h7);
    read_chk("excp_crmd", A_CRMD, 32'h8);
    check("excp_era", era, 32'h1C00_0100);
    read_chk("excp_estat", A_ESTAT, 32'h014B_0000);
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    read_chk("ertn_crmd", A_CRMD, 32'hF);

    csr_num = A_ERA; csr_wdata = 32'h1234_5678; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
    #1;
    check("era_old", era, 32'h1C00_0100);
    tick();
    csr_we = 1'b0;
    check("era_new", era, 32'h1234_5678);

    // Exception, return and CRMD write together: the exception wins.
    excp_flush = 1'b1; ertn_flush = 1'b1; ecode = 6'h03; esubcode = 3'h0; epc = 32'h1C00_0200;
    csr_write(A_CRMD, 32'h1F, 32'h1F);
    excp_flush = 1'b0; ertn_flush = 1'b0;
    read_chk("prio_crmd", A_CRMD, 32'h18);
    read_chk("prio_prmd", A_PRMD, 32'h7);
    check("prio_era", era, 32'h1C00_0200);
    ertn_flush = 1'b1;
    csr_write(A_CRMD, 32'h0, 32'h1F);
    ertn_flush = 1'b0;
    read_chk("ertn_vs_we", A_CRMD, 32'h7);

    // Periodic timer countdown and reload.
    csr_write(A_TCFG, 32'h13, 32'hFFFF_FFFF);
    read_chk("tcfg_rd", A_TCFG, 32'h13);
    for (int k = 16; k >= 1; k--) begin
      read_chk("tval_cnt", A_TVAL, k);
      csr_num = A_ESTAT;
      #1;
      check("is11_pre", csr_rdata & 32'h800, 32'h0);
      tick();
    end
    read_chk("tval_reload", A_TVAL, 32'd16);
    csr_num = A_ESTAT;
    #1;
    check("is11_fire", csr_rdata & 32'h800, 32'h800);
    csr_write(A_TVAL, 32'h55, 32'hFFFF_FFFF);
    read_chk("tval_ro", A_TVAL, 32'd15);
    csr_write(A_TCFG, 32'h0, 32'hFFFF_FFFF);
    read_chk("tval_stop", A_TVAL, 32'd0);

    // Timer interrupt, clear, one-shot and hold at zero.
    csr_write(A_ECFG, 32'h800, 32'hFFFF_FFFF);
    check("int_pend", {31'b0, has_int}, 32'h1);
    csr_write(A_TICLR, 32'h1, 32'h0);
    check("ticlr_nomask", {31'b0, has_int}, 32'h1);
    csr_write(A_TICLR, 32'h1, 32'h1);
    check("ticlr_clr", {31'b0, has_int}, 32'h0);
    csr_write(A_TCFG, 32'h9, 32'hFFFF_FFFF);
    read_chk("oneshot_ld", A_TVAL, 32'd8);
    for (int k = 0; k < 7; k++) tick();
    read_chk("oneshot_1", A_TVAL, 32'd1);
    check("int_before", {31'b0, has_int}, 32'h0);
    tick();
    read_chk("oneshot_0", A_TVAL, 32'd0);
    check("int_fire", {31'b0, has_int}, 32'h1);
    tick(); tick(); tick();
    read_chk("tval_hold", A_TVAL, 32'd0);
    csr_num = A_TICLR; csr_wdata = 32'h1; csr_wmask = 32'h1; csr_we = 1'b1;
    #1;
    check("int_clr_same", {31'b0, has_int}, 32'h1);
    tick();
    csr_we = 1'b0;
    check("int_clr_next", {31'b0, has_int}, 32'h0);

    // Clear and fire on the same edge: the fire wins.
    csr_write(A_TCFG, 32'h5, 32'hFFFF_FFFF);
    tick(); tick(); tick();
    read_chk("race_tval1", A_TVAL, 32'd1);
    csr_write(A_TICLR, 32'h1, 32'h1);
    csr_num = A_ESTAT;
    #1;
    check("race_is11", csr_rdata & 32'h800, 32'h800);
    read_chk("race_tval0", A_TVAL, 32'd0);

    // Reset overrides a concurrent TCFG write and exception commit.
    csr_write(A_TCFG, 32'h13, 32'hFFFF_FFFF);
    reset = 1'b1; excp_flush = 1'b1; epc = 32'hFFFF_0000;
    csr_write(A_TCFG, 32'h13, 32'hFFFF_FFFF);
    reset = 1'b0; excp_flush = 1'b0;
    read_chk("rst2_tcfg", A_TCFG, 32'h0);
    read_chk("rst2_tval", A_TVAL, 32'h0);
    read_chk("rst2_crmd", A_CRMD, 32'h8);
    read_chk("rst2_tid", A_TID, TIDR);
    check("rst2_era", era, 32'h0);
    check("rst2_has_int", {31'b0, has_int}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
